// File: rtl/int_ctl_pkg.sv
// Shared definitions for the eight-line interrupt controller: register select
// codes, the spurious vector code and the fixed-priority encoder.
package int_ctl_pkg;

    typedef enum logic {
        SEL_MASK = 1'b0,
        SEL_PEND = 1'b1
    } reg_sel_e;

    localparam logic [3:0] VEC_SPURIOUS = 4'b0000;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } prio_t;

    // Lowest set bit wins, so line 0 has the highest priority.
    function automatic prio_t prio_enc(input logic [7:0] act);
        prio_t r;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int_ctl_if.sv
// Peripheral-request, acknowledge and register bus of the interrupt controller.
interface int_ctl_if;
    logic [7:0] nirqin;
    logic       nack;
    logic       nwe;
    logic       a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       nirq;
    logic [7:0] vec;

    modport master (
        output nirqin, nack, nwe, a, din,
        input  dout, nirq, vec
    );

    modport slave (
        input  nirqin, nack, nwe, a, din,
        output dout, nirq, vec
    );
endinterface

// File: rtl/int_ctl_edge_det.sv
// Two-flop synchroniser plus falling-edge detector for one active-low request.
module int_ctl_edge_det (
    input  logic clk4,
    input  logic nreset,
    input  logic i_n,
    output logic o_fall
);
    logic r_s0;
    logic r_s1;
    logic r_prev;

    // All stages reset high so a line idling high never reports a spurious edge.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s0   <= i_n;
            r_s1   <= r_s0;
            r_prev <= r_s1;
        end
    end

    assign o_fall = r_prev & ~r_s1;
endmodule

// File: rtl/int_ctl.sv
// Eight-line prioritising interrupt controller: pending latch, software mask,
// registered nIRQ and vector hand-back on acknowledge.
module int_ctl
    import int_ctl_pkg::*;
#(
    parameter logic [3:0] VBASE = 4'hE
) (
    input  logic       clk4,
    input  logic       nreset,
    int_ctl_if.slave   bus
);
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic       r_nirq;
    logic [7:0] r_vec;

    logic [7:0] w_fall;
    logic [7:0] w_act;
    logic [7:0] w_wr_clr;
    logic [7:0] w_ack_clr;
    logic       w_ack;
    logic       w_wr_mask;
    logic       w_wr_pend;
    prio_t      w_prio;

    for (genvar g = 0; g < 8; g++) begin : g_line
        int_ctl_edge_det u_edge (
            .clk4   (clk4),
            .nreset (nreset),
            .i_n    (bus.nirqin[g]),
            .o_fall (w_fall[g])
        );
    end

    assign w_act     = r_pend & r_mask;
    assign w_prio    = prio_enc(w_act);
    assign w_ack     = ~bus.nack;
    assign w_wr_mask = ~bus.nwe && (bus.a == SEL_MASK);
    assign w_wr_pend = ~bus.nwe && (bus.a == SEL_PEND);
    assign w_wr_clr  = w_wr_pend ? bus.din : 8'h00;
    assign w_ack_clr = (w_ack && w_prio.found) ? (8'h01 << w_prio.idx) : 8'h00;

    // A fresh edge is OR'd in after the clears so it survives a same-cycle retire.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            r_pend <= 8'h00;
            r_mask <= 8'h00;
            r_nirq <= 1'b1;
            r_vec  <= {VBASE, VEC_SPURIOUS};
        end else begin
            r_pend <= (r_pend & ~(w_wr_clr | w_ack_clr)) | w_fall;
            if (w_wr_mask)
                r_mask <= bus.din;
            r_nirq <= ~|w_act;
            if (w_ack)
                r_vec <= w_prio.found ? {VBASE, 1'b1, w_prio.idx} : {VBASE, VEC_SPURIOUS};
        end
    end

    assign bus.dout = (bus.a == SEL_PEND) ? r_pend : r_mask;
    assign bus.nirq = r_nirq;
    assign bus.vec  = r_vec;
endmodule
